// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM access controller.
package ram_ctrl_pkg;

  localparam int SIZE_DEFAULT  = 8;
  localparam int READ_WAIT_MAX = 15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_access_controller.sv
// Single-transaction sequencer in front of the 8-bit RAM: latches the address,
// then strobes write or read-enable, then presents a response.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its payload stable until that edge;
// ready never depends combinationally on valid.
//
// All outputs are registered. They are computed from the next state, so each
// output is valid during the state it belongs to.
module ram_access_controller
  import ram_ctrl_pkg::*;
#(
  parameter int SIZE      = SIZE_DEFAULT,
  parameter int READ_WAIT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [SIZE-1:0] req_addr,
  input  logic [SIZE-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_write,
  output logic [SIZE-1:0] rsp_rdata,
  output logic            busy,
  output logic [SIZE-1:0] ram_address,
  output logic            ram_set_address,
  output logic            ram_set,
  output logic            ram_enable,
  output logic [SIZE-1:0] ram_data_in,
  input  logic [SIZE-1:0] ram_data_out
);

  // Out-of-range wait values are clamped so the 4-bit counter always terminates.
  localparam int RW = (READ_WAIT < 1) ? 1 :
                      (READ_WAIT > READ_WAIT_MAX) ? READ_WAIT_MAX : READ_WAIT;
  localparam logic [3:0] LAST = 4'(RW - 1);

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic            cap_write;
  logic [SIZE-1:0] cap_data;

  logic            req_ready_nx, busy_nx, rsp_valid_nx, rsp_write_nx;
  logic [SIZE-1:0] rsp_rdata_nx, ram_address_nx, ram_data_in_nx;
  logic            set_address_nx, set_nx, enable_nx;

  logic accept;
  assign accept = (state == S_IDLE) && req_valid && req_ready;

  // Next-state, wait counter and next registered output values.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    req_ready_nx   = 1'b0;
    busy_nx        = 1'b1;
    rsp_valid_nx   = 1'b0;
    rsp_write_nx   = rsp_write;
    rsp_rdata_nx   = rsp_rdata;
    ram_address_nx = ram_address;
    ram_data_in_nx = ram_data_in;
    set_address_nx = 1'b0;
    set_nx         = 1'b0;
    enable_nx      = 1'b0;

    case (state)
      S_IDLE:  if (accept) state_nx = S_ADDR;
      S_ADDR: begin
        state_nx = cap_write ? S_WRITE : S_READ;
        cnt_nx   = 4'd0;
      end
      S_WRITE: begin
        state_nx     = S_RESP;
        rsp_write_nx = 1'b1;
        rsp_rdata_nx = '0;
      end
      S_READ: begin
        if (cnt == LAST) begin
          state_nx     = S_RESP;
          rsp_write_nx = 1'b0;
          rsp_rdata_nx = ram_data_out;
          cnt_nx       = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_RESP:  if (rsp_valid && rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    case (state_nx)
      S_IDLE: begin
        req_ready_nx = 1'b1;
        busy_nx      = 1'b0;
      end
      S_ADDR: begin
        set_address_nx = 1'b1;
        ram_address_nx = req_addr;
        ram_data_in_nx = req_wdata;
      end
      S_WRITE: begin
        set_address_nx = 1'b1;
        set_nx         = 1'b1;
        enable_nx      = 1'b1;
        ram_data_in_nx = cap_data;
      end
      S_READ:  enable_nx    = 1'b1;
      S_RESP:  rsp_valid_nx = 1'b1;
      default: ;
    endcase
  end

  // State and wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Request capture, loaded only on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_write <= 1'b0;
      cap_data  <= '0;
    end else if (accept) begin
      cap_write <= req_write;
      cap_data  <= req_wdata;
    end
  end

  // Registered outputs; reset drops every strobe and any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready       <= 1'b0;
      busy            <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_write       <= 1'b0;
      rsp_rdata       <= '0;
      ram_address     <= '0;
      ram_set_address <= 1'b0;
      ram_set         <= 1'b0;
      ram_enable      <= 1'b0;
      ram_data_in     <= '0;
    end else begin
      req_ready       <= req_ready_nx;
      busy            <= busy_nx;
      rsp_valid       <= rsp_valid_nx;
      rsp_write       <= rsp_write_nx;
      rsp_rdata       <= rsp_rdata_nx;
      ram_address     <= ram_address_nx;
      ram_set_address <= set_address_nx;
      ram_set         <= set_nx;
      ram_enable      <= enable_nx;
      ram_data_in     <= ram_data_in_nx;
    end
  end

endmodule

// File: tb/tb_ram_access_controller.sv
// Bench for ram_access_controller: a simple RAM, a transaction-level model
// (cycles since acceptance + memory image + expected response queue), and a
// per-cycle compare process.
module tb_ram_access_controller;

  localparam int SIZE = 8;
  localparam int RW   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            req_valid, req_ready, req_write;
  logic [SIZE-1:0] req_addr, req_wdata;
  logic            rsp_valid, rsp_ready, rsp_write;
  logic [SIZE-1:0] rsp_rdata;
  logic            busy;
  logic [SIZE-1:0] ram_address, ram_data_in, ram_data_out;
  logic            ram_set_address, ram_set, ram_enable;

  ram_access_controller #(.SIZE(SIZE), .READ_WAIT(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .busy(busy),
    .ram_address(ram_address), .ram_set_address(ram_set_address),
    .ram_set(ram_set), .ram_enable(ram_enable),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // ---------------- RAM ----------------
  logic [7:0] ram_mem [256];
  logic [7:0] ram_alatch;
  always @(posedge clk) begin
    if (ram_set_address) ram_alatch <= ram_address;
    if (ram_enable && ram_set) ram_mem[ram_alatch] <= ram_data_in;
  end
  assign ram_data_out = (ram_enable && !ram_set) ? ram_mem[ram_alatch] : 8'h00;

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] mem_model [256];
  logic [8:0] exp_q [$];            // {rsp_write, rsp_rdata}
  bit         m_active = 1'b0;
  int         m_k = 0;              // cycles since acceptance
  bit         m_write = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_data = 8'h00;
  int         m_resp_at = 0;
  bit         ready_ok = 1'b0;
  bit         prev_sa = 1'b0;
  bit         prev_es = 1'b0;

  // Per-cycle compare against the model, then advance the model by one edge.
  always @(negedge clk) begin
    bit e_valid, e_sa, e_set, e_en;
    if (!rst_n) begin
      check("reset_outs", {req_ready, busy, rsp_valid, rsp_write, rsp_rdata,
                           ram_address, ram_set_address, ram_set, ram_enable, ram_data_in}, 32'd0);
      m_active = 1'b0;
      exp_q.delete();
      ready_ok = 1'b0;
      prev_sa  = 1'b0;
      prev_es  = 1'b0;
    end else begin
      e_valid = m_active && (m_k >= m_resp_at);
      e_sa    = m_active && (m_k == 1 || (m_write && m_k == 2));
      e_set   = m_active && m_write && (m_k == 2);
      e_en    = m_active && (m_write ? (m_k == 2) : (m_k >= 2 && m_k <= 1 + RW));
      check("req_ready", req_ready, !m_active && ready_ok);
      check("busy", busy, m_active);
      check("rsp_valid", rsp_valid, e_valid);
      if (e_valid && exp_q.size() > 0) check("rsp_payload", {rsp_write, rsp_rdata}, exp_q[0]);
      check("strobes", {ram_set_address, ram_set, ram_enable}, {e_sa, e_set, e_en});
      if (m_active && m_k < m_resp_at) check("ram_address", ram_address, m_addr);
      if (e_set) check("ram_data_in", ram_data_in, m_data);
      if ((ram_set || ram_enable) && !prev_es) check("strobe_order", prev_sa, 1'b1);
      prev_sa = ram_set_address;
      prev_es = ram_set || ram_enable;
      if (m_active) begin
        if (e_valid && rsp_ready) begin
          m_active = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          m_k++;
        end
      end else if (ready_ok && req_valid) begin
        m_active  = 1'b1;
        m_k       = 1;
        m_write   = req_write;
        m_addr    = req_addr;
        m_data    = req_wdata;
        m_resp_at = req_write ? 3 : 2 + RW;
        if (req_write) begin
          mem_model[req_addr] = req_wdata;
          exp_q.push_back({1'b1, 8'h00});
        end else begin
          exp_q.push_back({1'b0, mem_model[req_addr]});
        end
      end
      ready_ok = 1'b1;
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the
  // response handshake. lat counts cycles from acceptance to first rsp_valid.
  task automatic run_txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                         input int bp, input bit noise,
                         output int lat, output int en_cyc, output logic [7:0] rdata);
    int n;
    logic [7:0] first;
    lat = 0; en_cyc = 0; rdata = 8'h00;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    rsp_ready = (bp == 0);
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", n, 0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (noise) begin
      req_valid = 1'b1;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 8'd7;
      req_wdata = 8'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    do begin
      @(negedge clk);
      lat++;
      if (ram_enable) en_cyc++;
    end while (!rsp_valid && lat < 100);
    if (!rsp_valid) begin
      check("rsp_timeout", lat, 0);
      req_valid = 1'b0;
      return;
    end
    first = rsp_rdata;
    for (int i = 0; i < bp; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_rdata", rsp_rdata, first);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_ready", req_ready, 1'b0);
    end
    if (bp > 0) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    rdata = rsp_rdata;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, en_cyc, n;
    logic [7:0] rd, a, d;
    bit w;

    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = 8'($urandom);
      mem_model[i] = ram_mem[i];
    end
    ram_alatch = 8'h00;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    rst_n = 1'b1;
    #2;
    check("rel_req_ready_low", req_ready, 1'b0);
    @(posedge clk); #1;
    check("rel_req_ready_high", req_ready, 1'b1);

    // write then read
    run_txn(1'b1, 8'd3, 8'hAA, 0, 1'b0, lat, en_cyc, rd);
    check("wr_latency", lat, 3);
    run_txn(1'b0, 8'd3, 8'h00, 0, 1'b0, lat, en_cyc, rd);
    check("rd_latency", lat, 6);
    check("rd3_data", rd, 8'hAA);

    // multi-address
    run_txn(1'b1, 8'd5, 8'h55, 0, 1'b0, lat, en_cyc, rd);
    run_txn(1'b1, 8'd2, 8'h0F, 0, 1'b0, lat, en_cyc, rd);
    run_txn(1'b0, 8'd2, 8'h00, 0, 1'b0, lat, en_cyc, rd);
    check("rd2_data", rd, 8'h0F);
    run_txn(1'b0, 8'd5, 8'h00, 0, 1'b0, lat, en_cyc, rd);
    check("rd5_data", rd, 8'h55);

    // backpressure
    run_txn(1'b0, 8'd3, 8'h00, 5, 1'b0, lat, en_cyc, rd);
    check("bp_data", rd, 8'hAA);

    // top address, READ_WAIT enable window
    run_txn(1'b1, 8'hFF, 8'h81, 0, 1'b0, lat, en_cyc, rd);
    run_txn(1'b0, 8'hFF, 8'h00, 0, 1'b0, lat, en_cyc, rd);
    check("rdFF_latency", lat, 6);
    check("rdFF_enable_cycles", en_cyc, 4);
    check("rdFF_data", rd, 8'h81);

    // requests while busy are ignored
    run_txn(1'b1, 8'd7, 8'h77, 0, 1'b0, lat, en_cyc, rd);
    run_txn(1'b0, 8'd3, 8'h00, 0, 1'b1, lat, en_cyc, rd);
    check("noise_rd3_data", rd, 8'hAA);
    run_txn(1'b0, 8'd7, 8'h00, 0, 1'b0, lat, en_cyc, rd);
    check("rd7_data", rd, 8'h77);

    // reset during READ
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd5; rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    check("pre_rst_enable", ram_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {rsp_valid, busy, ram_address, ram_set_address, ram_set,
                             ram_enable, ram_data_in}, 32'd0);
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", req_ready, 1'b1);
    run_txn(1'b1, 8'd0, 8'h3C, 0, 1'b0, lat, en_cyc, rd);
    run_txn(1'b0, 8'd0, 8'h00, 0, 1'b0, lat, en_cyc, rd);
    check("rd0_data", rd, 8'h3C);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      d = 8'($urandom);
      run_txn(w, a, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, en_cyc, rd);
      check("rand_latency", lat, w ? 3 : 2 + RW);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
